window_gen: RTL and testbench
=============================

WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 Parameter IMG_W, 128, image width in pixels (>= 3).
REQ-002 Parameter IMG_H, 128, image height in pixels (>= 3).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  pixel qualifier; one pixel accepted per cycle when high, no backpressure.
REQ-006 pixel  input  8  unsigned grayscale pixel, raster order (row-major, top-left first).
REQ-007 out_valid  output  1  high for one cycle per complete 3x3 window.
REQ-008 R0..R8  output  20 each  signed window taps: R0 R1 R2 top row, R3 R4 R5 middle row, R6 R7 R8 bottom row, left to right; each is the pixel zero-extended to 20 bits.
REQ-009 out_row, out_col  output  16 each  image coordinates of window centre (R4).
REQ-010 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-011 Block SHALL keep col and row counters of the next pixel; col wraps IMG_W-1 -> 0 and increments row; row wraps IMG_H-1 -> 0.
REQ-012 Block SHALL hold two line buffers of IMG_W x 8 bits storing the previous two rows, plus a 3x3 register array shifted left by one column per accepted pixel.
REQ-013 On an accepted pixel at (r,c), new right column SHALL be {line2[c], line1[c], pixel} (top, middle, bottom); line2[c] <= line1[c], line1[c] <= pixel.
REQ-014 out_valid SHALL assert exactly one cycle after accepting a pixel with r >= 2 and c >= 2, with window centred at (r-1, c-1) and out_row = r-1, out_col = c-1.
REQ-015 No window SHALL be emitted across a row boundary; border pixels produce no output; frame yields exactly (IMG_W-2)*(IMG_H-2) windows.
REQ-016 Cycles with in_valid low SHALL not change counters, buffers, or window; out_valid low on the following cycle.
REQ-017 FSM states: IDLE (no pixel yet in frame), FILL (rows 0-1), STREAM (rows 2..IMG_H-1), DONE (one cycle, frame_done high); IDLE->FILL on first accepted pixel, FILL->STREAM on accepting (1, IMG_W-1), STREAM->DONE on accepting (IMG_H-1, IMG_W-1), DONE->IDLE unconditionally.
REQ-018 A pixel with in_valid high in DONE SHALL be accepted as (0,0) of the next frame and state moves to FILL.
REQ-019 R0..R8, out_row, out_col SHALL be registered and hold last values while out_valid low.
REQ-020 Final window of a frame and frame_done SHALL assert in the same cycle.

Reset
REQ-021 While reset high: state IDLE, row = col = 0, out_valid = 0, frame_done = 0, R0..R8 = 0, out_row = out_col = 0.
REQ-022 Line-buffer contents need not be cleared; no output SHALL depend on them before rewritten in the new frame.
REQ-023 Reset mid-frame SHALL discard the partial frame; next accepted pixel is (0,0).

Structure
REQ-024 Shared package SHALL hold PIX_W = 8, TAP_W = 20, COORD_W = 16, and the FSM state encoding.
REQ-025 One sub-module line_buf (IMG_W-deep, 8-bit, one write and one read at same address per cycle, read-before-write) SHALL be instantiated twice.
REQ-026 R0..R8 SHALL connect directly to the downstream Sobel stage without further width conversion.

Verification (IMG_W = 8, IMG_H = 6)
REQ-027 Pixel value = 8*r + c, continuous in_valid -> 24 windows; first at out_row=1,out_col=1 with R0..R8 = 0,1,2,8,9,10,16,17,18; one cycle after pixel (2,2).
REQ-028 Same frame with in_valid toggled every other cycle -> identical 24 windows in same order, no out_valid during gaps.
REQ-029 Pixel 255 at (3,4), all others 0 -> R8=255 in window centred (2,3), R4=255 in (3,4), R0=255 in (4,5); all taps 20'd255 (not negative).
REQ-030 Two back-to-back frames, no idle cycle -> frame_done pulses twice, coincident with 24th window each; second frame first window again at (1,1).
REQ-031 Reset asserted after pixel (3,5), then fresh frame -> no out_valid before (2,2) of new frame; 24 correct windows.

Source files
------------

// File: rtl/window_gen_pkg.sv
// Shared widths, FSM encoding and tap-conversion helper for the 3x3 window
// generator and its line buffers.
package window_gen_pkg;

    localparam int PIX_W   = 8;
    localparam int TAP_W   = 20;
    localparam int COORD_W = 16;

    typedef logic [PIX_W-1:0]          pix_t;
    typedef logic signed [TAP_W-1:0]   tap_t;
    typedef logic [COORD_W-1:0]        coord_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Taps feed a signed Sobel stage, so pixels are zero-extended to stay positive.
    function automatic tap_t pix_to_tap(input pix_t p);
        return tap_t'({{(TAP_W-PIX_W){1'b0}}, p});
    endfunction

endpackage

// File: rtl/window_gen_if.sv
// Pixel stream in, 3x3 window taps plus centre coordinates out.
interface window_gen_if;
    import window_gen_pkg::*;

    logic   in_valid;
    pix_t   pixel;

    logic   out_valid;
    tap_t   R0, R1, R2, R3, R4, R5, R6, R7, R8;
    coord_t out_row;
    coord_t out_col;
    logic   frame_done;

    modport slave (
        input  in_valid, pixel,
        output out_valid, R0, R1, R2, R3, R4, R5, R6, R7, R8,
               out_row, out_col, frame_done
    );

    modport master (
        output in_valid, pixel,
        input  out_valid, R0, R1, R2, R3, R4, R5, R6, R7, R8,
               out_row, out_col, frame_done
    );

endinterface

// File: rtl/window_gen_line_buf.sv
// One image row of pixel storage: single address per cycle, the read returns
// the value stored before this cycle's write lands (read-before-write).
module line_buf
    import window_gen_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int WIDTH = PIX_W,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage arrays get no reset; every location is rewritten before
    // any output can depend on it, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window_gen.sv
// Raster-order pixel stream to 3x3 sliding window, using two row buffers and
// a shifting 3x3 register array; border pixels produce no window.
module window_gen
    import window_gen_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
) (
    input  logic        clk,
    input  logic        reset,
    window_gen_if.slave bus
);

    localparam int     AW       = $clog2(IMG_W);
    localparam coord_t LAST_COL = coord_t'(IMG_W - 1);
    localparam coord_t LAST_ROW = coord_t'(IMG_H - 1);

    logic   accept;
    coord_t row_q, row_d;
    coord_t col_q, col_d;
    logic   end_of_row, end_of_frame, emit;
    pix_t   line1_rd, line2_rd;
    pix_t   col_new [3];
    pix_t   win_q   [3][3];
    tap_t   tap_d   [9];
    tap_t   tap_q   [9];
    logic   out_valid_q;
    coord_t out_row_q, out_col_q;
    state_e state_q;
    logic   frame_done_q;

    assign accept       = bus.in_valid;
    assign end_of_row   = (col_q == LAST_COL);
    assign end_of_frame = end_of_row && (row_q == LAST_ROW);
    assign emit         = accept && (row_q >= coord_t'(2)) && (col_q >= coord_t'(2));

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (accept) begin
            if (end_of_row) begin
                col_d = '0;
                row_d = end_of_frame ? '0 : row_q + coord_t'(1);
            end else begin
                col_d = col_q + coord_t'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    // line1 holds the previous row, line2 the one before it.
    line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line1 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_q[AW-1:0]),
        .wdata_i (bus.pixel),
        .rdata_o (line1_rd)
    );

    line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line2 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_q[AW-1:0]),
        .wdata_i (line1_rd),
        .rdata_o (line2_rd)
    );

    assign col_new[0] = line2_rd;
    assign col_new[1] = line1_rd;
    assign col_new[2] = bus.pixel;

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
                win_q[r][2] <= col_new[r];
            end
        end
    end

    // Taps of the window as it will be after this pixel shifts in.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            tap_d[3*r + 0] = pix_to_tap(win_q[r][1]);
            tap_d[3*r + 1] = pix_to_tap(win_q[r][2]);
            tap_d[3*r + 2] = pix_to_tap(col_new[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            tap_q       <= '{default: '0};
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            out_valid_q <= emit;
            if (emit) begin
                tap_q     <= tap_d;
                out_row_q <= row_q - coord_t'(1);
                out_col_q <= col_q - coord_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= accept && end_of_frame && (state_q == ST_STREAM);
            case (state_q)
                ST_IDLE: begin
                    if (accept) state_q <= ST_FILL;
                end
                ST_FILL: begin
                    if (accept && end_of_row && (row_q == coord_t'(1))) state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (accept && end_of_frame) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= accept ? ST_FILL : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.R0         = tap_q[0];
    assign bus.R1         = tap_q[1];
    assign bus.R2         = tap_q[2];
    assign bus.R3         = tap_q[3];
    assign bus.R4         = tap_q[4];
    assign bus.R5         = tap_q[5];
    assign bus.R6         = tap_q[6];
    assign bus.R7         = tap_q[7];
    assign bus.R8         = tap_q[8];
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen on an 8x6 image: every cycle is compared against a
// model that forms each window straight from the stored image array.
module tb_window_gen;
    import window_gen_pkg::*;

    localparam int W = 8;
    localparam int H = 6;

    logic clk = 1'b0;
    logic reset;

    window_gen_if bus ();

    window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int           img       [H][W];
    int           frame_pix [H][W];
    int           m_r, m_c;
    logic [179:0] last_taps;
    logic [31:0]  last_coord;
    logic [179:0] obs       [H][W];
    int           win_seen, done_seen, done_with_win;

    typedef struct {
        int pr, pc;
        int wr, wc;
        int tap;
    } imp_vec_t;

    imp_vec_t imp_tab [6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [179:0] dut_taps();
        return {bus.R0, bus.R1, bus.R2, bus.R3, bus.R4, bus.R5, bus.R6, bus.R7, bus.R8};
    endfunction

    // Window centred on (r-1, c-1): rows r-2..r, cols c-2..c, row-major.
    function automatic logic [179:0] ref_taps(input int r, input int c);
        logic [179:0] t;
        t = '0;
        for (int k = 0; k < 9; k++) begin
            t = {t[159:0], 20'(img[r - 2 + k / 3][c - 2 + k % 3])};
        end
        return t;
    endfunction

    task automatic cycle(input logic v, input logic [7:0] p);
        logic         ev, ed;
        logic [179:0] et;
        logic [31:0]  ec;
        ev = 1'b0;
        ed = 1'b0;
        et = '0;
        ec = '0;
        bus.in_valid = v;
        bus.pixel    = p;
        if (v) begin
            img[m_r][m_c] = int'(p);
            if (m_r >= 2 && m_c >= 2) begin
                ev = 1'b1;
                et = ref_taps(m_r, m_c);
                ec = {16'(m_r - 1), 16'(m_c - 1)};
            end
            ed = (m_r == H - 1) && (m_c == W - 1);
            m_c++;
            if (m_c == W) begin
                m_c = 0;
                m_r = (m_r == H - 1) ? 0 : m_r + 1;
            end
        end
        @(posedge clk);
        #1;
        if (ev) begin
            last_taps  = et;
            last_coord = ec;
        end
        check("out_valid", 256'(bus.out_valid), 256'(ev));
        check("frame_done", 256'(bus.frame_done), 256'(ed));
        check(ev ? "window_taps" : "held_taps", 256'(dut_taps()), 256'(last_taps));
        check(ev ? "window_coords" : "held_coords", 256'({bus.out_row, bus.out_col}), 256'(last_coord));
        if (bus.out_valid) begin
            win_seen++;
            if (bus.out_row < 16'(H) && bus.out_col < 16'(W)) obs[bus.out_row][bus.out_col] = dut_taps();
        end
        if (bus.frame_done) done_seen++;
        if (bus.frame_done && bus.out_valid) done_with_win++;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.pixel    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 256'(bus.out_valid), 256'(0));
        check("reset_frame_done", 256'(bus.frame_done), 256'(0));
        check("reset_taps", 256'(dut_taps()), 256'(0));
        check("reset_coords", 256'({bus.out_row, bus.out_col}), 256'(0));
        reset      = 1'b0;
        m_r        = 0;
        m_c        = 0;
        last_taps  = '0;
        last_coord = '0;
    endtask

    // gap_mode 0: continuous, 1: idle after every pixel, 2: random idles with junk pixels.
    task automatic send_frame(input int gap_mode);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gap_mode == 2) repeat ($urandom_range(0, 2)) cycle(1'b0, 8'($urandom));
                cycle(1'b1, 8'(frame_pix[r][c]));
                if (gap_mode == 1) cycle(1'b0, 8'($urandom));
            end
        end
    endtask

    task automatic clear_stats();
        win_seen      = 0;
        done_seen     = 0;
        done_with_win = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) obs[r][c] = '1;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame_pix[r][c] = 8 * r + c;
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame_pix[r][c] = int'($urandom_range(0, 255));
    endtask

    initial begin
        logic [179:0] first_exp;
        logic [179:0] imp_exp;

        imp_tab[0] = '{pr: 3, pc: 4, wr: 2, wc: 3, tap: 8};
        imp_tab[1] = '{pr: 3, pc: 4, wr: 3, wc: 4, tap: 4};
        imp_tab[2] = '{pr: 3, pc: 4, wr: 4, wc: 5, tap: 0};
        imp_tab[3] = '{pr: 2, pc: 0, wr: 1, wc: 1, tap: 6};
        imp_tab[4] = '{pr: 0, pc: 7, wr: 1, wc: 6, tap: 2};
        imp_tab[5] = '{pr: 5, pc: 7, wr: 4, wc: 6, tap: 8};

        first_exp = {20'd0, 20'd1, 20'd2, 20'd8, 20'd9, 20'd10, 20'd16, 20'd17, 20'd18};

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.pixel    = '0;
        apply_reset();

        // Ramp frame, continuous valid.
        fill_ramp();
        clear_stats();
        send_frame(0);
        cycle(1'b0, 8'd0);
        check("ramp_windows", 256'(win_seen), 256'(24));
        check("ramp_frame_done", 256'(done_seen), 256'(1));
        check("ramp_first_window", 256'(obs[1][1]), 256'(first_exp));

        // Same ramp with valid toggled every other cycle.
        clear_stats();
        send_frame(1);
        check("gap_windows", 256'(win_seen), 256'(24));
        check("gap_first_window", 256'(obs[1][1]), 256'(first_exp));

        // Single bright pixel in a black frame lands on the expected tap.
        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) frame_pix[r][c] = 0;
            frame_pix[imp_tab[i].pr][imp_tab[i].pc] = 255;
            clear_stats();
            send_frame(0);
            cycle(1'b0, 8'd0);
            imp_exp = '0;
            imp_exp[(8 - imp_tab[i].tap) * 20 +: 20] = 20'd255;
            check($sformatf("impulse_%0d", i), 256'(obs[imp_tab[i].wr][imp_tab[i].wc]), 256'(imp_exp));
        end

        // Two frames back to back; second frame's first pixel arrives in DONE.
        clear_stats();
        fill_random();
        send_frame(0);
        fill_random();
        send_frame(0);
        cycle(1'b0, 8'd0);
        check("b2b_windows", 256'(win_seen), 256'(48));
        check("b2b_frame_done", 256'(done_seen), 256'(2));
        check("b2b_done_with_last_window", 256'(done_with_win), 256'(2));

        // Reset after pixel (3,5), then a fresh frame.
        fill_random();
        for (int i = 0; i < 3 * W + 6; i++) cycle(1'b1, 8'(frame_pix[i / W][i % W]));
        apply_reset();
        clear_stats();
        fill_ramp();
        send_frame(2);
        cycle(1'b0, 8'd0);
        check("post_reset_windows", 256'(win_seen), 256'(24));
        check("post_reset_first_window", 256'(obs[1][1]), 256'(first_exp));

        // Random pixels and random idle gaps over several frames.
        clear_stats();
        for (int f = 0; f < 3; f++) begin
            fill_random();
            send_frame(2);
        end
        cycle(1'b0, 8'd0);
        check("random_windows", 256'(win_seen), 256'(72));
        check("random_frame_done", 256'(done_seen), 256'(3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
